// File: rtl/gp_register_file.sv
// General-purpose register file: one write port, a tri-state bus read port and an always-driven peek port.
// Optional increment/decrement with zero/carry flags when GP_REGFILE_INCDEC_EN is defined.
module gp_register_file #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              store,
    input  logic [ADDR_W-1:0] wsel,
    input  logic              load,
    input  logic [ADDR_W-1:0] rsel,
    output logic [WIDTH-1:0]  data_out,
    input  logic [ADDR_W-1:0] peek_sel,
    output logic [WIDTH-1:0]  peek_out,
`ifdef GP_REGFILE_INCDEC_EN
    input  logic              inc,
    input  logic              dec,
`endif
    output logic              zero,
    output logic              carry
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] cur_val;
    logic [WIDTH-1:0] next_val;
    logic             wr_en;
    logic             flag_upd;
    logic             next_carry;

    assign cur_val  = regs[wsel];
    assign data_out = load ? regs[rsel] : {WIDTH{1'bz}};
    assign peek_out = regs[peek_sel];

    // store wins over inc/dec; inc and dec together only refresh the flags.
    always_comb begin
        wr_en      = 1'b0;
        flag_upd   = 1'b0;
        next_val   = data_in;
        next_carry = 1'b0;
        if (store) begin
            wr_en    = 1'b1;
            flag_upd = 1'b1;
        end
`ifdef GP_REGFILE_INCDEC_EN
        else if (inc && !dec) begin
            wr_en      = 1'b1;
            flag_upd   = 1'b1;
            next_val   = cur_val + ONE;
            next_carry = (cur_val == {WIDTH{1'b1}});
        end else if (dec && !inc) begin
            wr_en      = 1'b1;
            flag_upd   = 1'b1;
            next_val   = cur_val - ONE;
            next_carry = (cur_val == '0);
        end else if (inc && dec) begin
            flag_upd = 1'b1;
            next_val = cur_val;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            zero <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[wsel] <= next_val;
            end
            if (flag_upd) begin
                zero <= (next_val == '0);
            end
        end
    end

`ifdef GP_REGFILE_INCDEC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (flag_upd) begin
            carry <= next_carry;
        end
    end
`else
    assign carry = 1'b0;
`endif

endmodule

// File: doc/gp_register_file.md
GP_REGISTER_FILE -- requirements
Module: gp_register_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving register and bus width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of registers (power of two, >= 2); ADDR_W = clog2(DEPTH).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 data_in  input  WIDTH  write data.
REQ-007 store  input  1  write data_in into register wsel on the next rising edge.
REQ-008 wsel  input  ADDR_W  write / inc / dec target index.
REQ-009 load  input  1  drive register rsel onto data_out.
REQ-010 rsel  input  ADDR_W  tri-state read index.
REQ-011 data_out  output  WIDTH  tri-state bus, high-Z when load=0.
REQ-012 peek_sel  input  ADDR_W  non-bus read index.
REQ-013 peek_out  output  WIDTH  always-driven combinational read of register peek_sel.
REQ-014 inc  input  1  increment register wsel (only when GP_REGFILE_INCDEC_EN is defined).
REQ-015 dec  input  1  decrement register wsel (only when GP_REGFILE_INCDEC_EN is defined).
REQ-016 zero  output  1  registered flag: last modified value was zero.
REQ-017 carry  output  1  registered flag: last inc/dec wrapped.

Function
REQ-018 Each register SHALL update only on a rising clk edge; all reads SHALL be combinational and SHALL return the pre-edge value (no write-through).
REQ-019 data_out SHALL equal register[rsel] when load=1 and SHALL be all high-Z when load=0.
REQ-020 peek_out SHALL equal register[peek_sel] regardless of load.
REQ-021 With store=1 the edge SHALL write data_in to register[wsel]; zero SHALL become (data_in==0); carry SHALL become 0.
REQ-022 With store=0, inc=1, dec=0 the edge SHALL write register[wsel]+1 modulo 2^WIDTH; carry SHALL become 1 only when the old value was all ones (wrap to 0); zero SHALL reflect the new value.
REQ-023 With store=0, inc=0, dec=1 the edge SHALL write register[wsel]-1 modulo 2^WIDTH; carry SHALL become 1 only when the old value was 0 (wrap to all ones); zero SHALL reflect the new value.
REQ-024 Priority: store SHALL override inc and dec in the same cycle.
REQ-025 inc=1 and dec=1 with store=0 SHALL leave the register unchanged and SHALL set zero from the unchanged value and carry to 0.
REQ-026 With store=inc=dec=0, no register and no flag SHALL change.
REQ-027 Only register[wsel] SHALL change on any edge; all other registers SHALL hold.
REQ-028 load SHALL NOT affect any stored state; reading and writing the same index in one cycle SHALL present the old value until the edge.

Reset
REQ-029 On rst_n=0, every register, zero and carry SHALL clear to 0 immediately, independent of clk.
REQ-030 While rst_n=0, store/inc/dec SHALL be ignored; data_out SHALL still follow load (driving 0s or high-Z).
REQ-031 The first edge after rst_n rises SHALL operate normally; a reset asserted mid-operation SHALL discard any pending write.

Configuration
REQ-032 Macro GP_REGFILE_INCDEC_EN defined: inc/dec ports and the behaviour of REQ-022, REQ-023 and REQ-025 SHALL be present.
REQ-033 Macro GP_REGFILE_INCDEC_EN undefined: inc/dec ports SHALL be absent, carry SHALL be tied to 0, and only store SHALL modify state (zero still updates on store).

Verification
REQ-034 Reset: rst_n=0 mid-clock-cycle -> all peek_out reads 0x00, zero=0, carry=0 without waiting for an edge.
REQ-035 Write/read: store 0xA5 to reg 2, 0x3C to reg 1 -> load rsel=2 gives 0xA5, load=0 gives Z, peek_sel=1 gives 0x3C, other regs 0x00.
REQ-036 Wrap (INCDEC_EN): store 0xFF to reg 3, then inc -> reg 3=0x00, carry=1, zero=1; then dec -> 0xFF, carry=1, zero=0.
REQ-037 Priority: store=1, inc=1, data_in=0x10 on reg 0 -> reg 0=0x10, carry=0; inc=dec=1 on 0x10 -> unchanged, carry=0.
REQ-038 Read-during-write: store 0x55 to reg 1 (holding 0x22) with load rsel=1 -> data_out 0x22 before the edge, 0x55 after.
REQ-039 Build without GP_REGFILE_INCDEC_EN, WIDTH=16, DEPTH=8 -> store/load on all 8 indices pass; carry stays 0.
